control_sequencer: RTL and testbench

Hardwired control unit that generates the datapath control strobes, one step per clock. It replaces the hand-sequenced T-state stimulus currently used to exercise the datapath. The block fetches through the PC/MAR/MDR path, decodes the opcode in IR[31:27], and walks per-class step sequences. It sits beside the datapath and drives its enables, bus selects, ALU opcode, and memory Read/Write.

---
 rtl/control_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the bus-based datapath: a fetch sequence (T0-T2) is
// followed by per-opcode-class execute steps, one step per clock.
// Optional build macro: CONTROL_ILLEGAL_TRAP_EN adds the 'illegal' output. With it, unlisted
// opcodes trap to Halt instead of executing as nop.
module control_sequencer #(
  parameter int unsigned          IR_WIDTH = 32,
  parameter int unsigned          OP_WIDTH = 5,
  parameter logic [OP_WIDTH-1:0]  INC_OP   = 5'b00011
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic                Stop,
  output logic                PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout, Rout,
  output logic                PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
  output logic                Gra, Grb, Grc,
  output logic                IncPC, Read, Write,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic                Run
`ifdef CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);

  localparam logic [OP_WIDTH-1:0] OpLd   = 5'b00000;
  localparam logic [OP_WIDTH-1:0] OpLdi  = 5'b00001;
  localparam logic [OP_WIDTH-1:0] OpSt   = 5'b00010;
  localparam logic [OP_WIDTH-1:0] OpAdd  = 5'b00011;
  localparam logic [OP_WIDTH-1:0] OpAnd  = 5'b00101;
  localparam logic [OP_WIDTH-1:0] OpOr   = 5'b00110;
  localparam logic [OP_WIDTH-1:0] OpRol  = 5'b01010;
  localparam logic [OP_WIDTH-1:0] OpAddi = 5'b01011;
  localparam logic [OP_WIDTH-1:0] OpAndi = 5'b01100;
  localparam logic [OP_WIDTH-1:0] OpOri  = 5'b01101;
  localparam logic [OP_WIDTH-1:0] OpMul  = 5'b01110;
  localparam logic [OP_WIDTH-1:0] OpDiv  = 5'b01111;
  localparam logic [OP_WIDTH-1:0] OpNeg  = 5'b10000;
  localparam logic [OP_WIDTH-1:0] OpNot  = 5'b10001;
  localparam logic [OP_WIDTH-1:0] OpNop  = 5'b11000;
  localparam logic [OP_WIDTH-1:0] OpHalt = 5'b11001;

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_t;

  typedef enum logic [3:0] {
    ClsNop, ClsHalt, ClsReg, ClsImm, ClsUnary, ClsMulDiv, ClsLdi, ClsLd, ClsSt, ClsIllegal
  } cls_t;

  state_t              state_q, state_d;
  cls_t                cls;
  logic [OP_WIDTH-1:0] opcode;
  logic                last_step;
  logic                illegal_q;
  logic                unused_ir;

  assign opcode    = IR[IR_WIDTH-1 -: OP_WIDTH];
  assign unused_ir = ^IR[IR_WIDTH-OP_WIDTH-1:0];

  // Classify the opcode into its step-sequence family.
  always_comb begin
    cls = ClsNop;
    if (opcode == OpLd)                              cls = ClsLd;
    else if (opcode == OpLdi)                        cls = ClsLdi;
    else if (opcode == OpSt)                         cls = ClsSt;
    else if (opcode >= OpAdd && opcode <= OpRol)     cls = ClsReg;
    else if (opcode >= OpAddi && opcode <= OpOri)    cls = ClsImm;
    else if (opcode == OpMul || opcode == OpDiv)     cls = ClsMulDiv;
    else if (opcode == OpNeg || opcode == OpNot)     cls = ClsUnary;
    else if (opcode == OpNop)                        cls = ClsNop;
    else if (opcode == OpHalt)                       cls = ClsHalt;
`ifdef CONTROL_ILLEGAL_TRAP_EN
    else                                             cls = ClsIllegal;
`else
    else                                             cls = ClsNop;
`endif
  end

  // Flag the final step of the current instruction; Stop is honoured only there.
  always_comb begin
    last_step = 1'b0;
    unique case (state_q)
      StT2:    last_step = (cls == ClsNop);
      StT4:    last_step = (cls == ClsUnary);
      StT5:    last_step = (cls == ClsReg) || (cls == ClsImm) || (cls == ClsLdi);
      StT6:    last_step = (cls == ClsMulDiv);
      StT7:    last_step = (cls == ClsLd) || (cls == ClsSt);
      default: last_step = 1'b0;
    endcase
  end

  // Next-step selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = (cls == ClsHalt || cls == ClsIllegal) ? StHalt :
                         last_step ? (Stop ? StHalt : StT0) : StT3;
      StT3:    state_d = StT4;
      StT4:    state_d = last_step ? (Stop ? StHalt : StT0) : StT5;
      StT5:    state_d = last_step ? (Stop ? StHalt : StT0) : StT6;
      StT6:    state_d = last_step ? (Stop ? StHalt : StT0) : StT7;
      StT7:    state_d = Stop ? StHalt : StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  // Step register and sticky illegal-opcode flag; clear forces Reset_state at once.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q   <= StReset;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (state_q == StT2 && cls == ClsIllegal) illegal_q <= 1'b1;
    end
  end

`ifdef CONTROL_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

  // Decode control strobes from the present step and instruction class.
  always_comb begin
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout, Rout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write} = '0;
    alu_op = '0;
    Run    = (state_q != StReset) && (state_q != StHalt);
    unique case (state_q)
      StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      StT1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      StT2: begin MDRout = 1'b1; IRin = 1'b1; end
      StT3: begin
        unique case (cls)
          ClsReg, ClsImm:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsUnary:            begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
          ClsMulDiv:           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsLdi, ClsLd, ClsSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      StT4: begin
        unique case (cls)
          ClsReg:              begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
          ClsImm: begin
            Cout = 1'b1; Zin = 1'b1;
            alu_op = (opcode == OpAddi) ? OpAdd : (opcode == OpAndi) ? OpAnd : OpOr;
          end
          ClsUnary:            begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMulDiv:           begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
          ClsLdi, ClsLd, ClsSt: begin Cout = 1'b1; Zin = 1'b1; alu_op = INC_OP; end
          default: ;
        endcase
      end
      StT5: begin
        unique case (cls)
          ClsReg, ClsImm, ClsLdi: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMulDiv:              begin Zlowout = 1'b1; LOin = 1'b1; end
          ClsLd, ClsSt:           begin Zlowout = 1'b1; MARin = 1'b1; end
          default: ;
        endcase
      end
      StT6: begin
        unique case (cls)
          ClsMulDiv: begin Zhighout = 1'b1; HIin = 1'b1; end
          ClsLd:     begin Read = 1'b1; MDRin = 1'b1; end
          // Read stays low so MDR captures the register value from the bus.
          ClsSt:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          default: ;
        endcase
      end
      StT7: begin
        unique case (cls)
          ClsLd:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsSt:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-instruction step model feeds an expectation
// queue that a single negedge process compares against the DUT, plus literal spot checks.
module tb_control_sequencer;

  typedef struct packed {
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
    logic Gra, Grb, Grc;
    logic IncPC, Read, Write;
    logic [4:0] alu_op;
    logic Run;
  } ctl_t;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR    = 32'h0;
  logic        Stop  = 1'b0;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0] alu_op;
`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic illegal;
`endif

  int checks   = 0;
  int failures = 0;
  int bus_viol = 0;
  int rw_viol  = 0;
  int hilo_viol = 0;
  ctl_t exp_q[$];
  ctl_t obs;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .BAout(BAout), .Cout(Cout), .Rout(Rout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
    .alu_op(alu_op), .Run(Run)
`ifdef CONTROL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 Clock = ~Clock;

  assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, Cout, Rout,
                PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
                Gra, Grb, Grc, IncPC, Read, Write, alu_op, Run};

  // Instruction-level model: how many steps each opcode takes from T0.
  function automatic int n_steps(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd2) return 8;
    if (op == 5'd14 || op == 5'd15) return 7;
    if ((op >= 5'd3 && op <= 5'd13) || op == 5'd1) return 6;
    if (op == 5'd16 || op == 5'd17) return 5;
    return 3;
  endfunction

  function automatic bit listed(input logic [4:0] op);
    return (op <= 5'd17) || op == 5'd24 || op == 5'd25;
  endfunction

  function automatic bit ends_in_halt(input logic [4:0] op, input logic stop);
`ifdef CONTROL_ILLEGAL_TRAP_EN
    if (!listed(op)) return 1'b1;
`endif
    return op == 5'd25 || stop;
  endfunction

  // Strobes required at step i (0 = T0) of an instruction with opcode op.
  function automatic ctl_t step_vec(input logic [4:0] op, input int i);
    ctl_t c = '0;
    c.Run = 1'b1;
    if (i == 0) begin c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1; end
    else if (i == 1) begin c.Zlowout = 1; c.PCin = 1; c.Read = 1; c.MDRin = 1; end
    else if (i == 2) begin c.MDRout = 1; c.IRin = 1; end
    else if (op >= 5'd3 && op <= 5'd13) begin
      if (i == 3) begin c.Grb = 1; c.Rout = 1; c.Yin = 1; end
      if (i == 4 && op <= 5'd10) begin c.Grc = 1; c.Rout = 1; c.Zin = 1; c.alu_op = op; end
      if (i == 4 && op >= 5'd11) begin
        c.Cout = 1; c.Zin = 1;
        c.alu_op = (op == 5'd11) ? 5'd3 : (op == 5'd12) ? 5'd5 : 5'd6;
      end
      if (i == 5) begin c.Zlowout = 1; c.Gra = 1; c.Rin = 1; end
    end else if (op == 5'd16 || op == 5'd17) begin
      if (i == 3) begin c.Grb = 1; c.Rout = 1; c.Zin = 1; c.alu_op = op; end
      if (i == 4) begin c.Zlowout = 1; c.Gra = 1; c.Rin = 1; end
    end else if (op == 5'd14 || op == 5'd15) begin
      if (i == 3) begin c.Gra = 1; c.Rout = 1; c.Yin = 1; end
      if (i == 4) begin c.Grb = 1; c.Rout = 1; c.Zin = 1; c.alu_op = op; end
      if (i == 5) begin c.Zlowout = 1; c.LOin = 1; end
      if (i == 6) begin c.Zhighout = 1; c.HIin = 1; end
    end else if (op <= 5'd2) begin
      if (i == 3) begin c.Grb = 1; c.BAout = 1; c.Yin = 1; end
      if (i == 4) begin c.Cout = 1; c.Zin = 1; c.alu_op = 5'b00011; end
      if (i == 5 && op == 5'd1) begin c.Zlowout = 1; c.Gra = 1; c.Rin = 1; end
      if (i == 5 && op != 5'd1) begin c.Zlowout = 1; c.MARin = 1; end
      if (i == 6 && op == 5'd0) begin c.Read = 1; c.MDRin = 1; end
      if (i == 6 && op == 5'd2) begin c.Gra = 1; c.Rout = 1; c.MDRin = 1; end
      if (i == 7 && op == 5'd0) begin c.MDRout = 1; c.Gra = 1; c.Rin = 1; end
      if (i == 7 && op == 5'd2) c.Write = 1;
    end
    return c;
  endfunction

  // Single compare process: one expected vector per cycle while the queue holds any.
  always @(negedge Clock) begin
    if ((PCout + Zhighout + Zlowout + MDRout + HIout + LOout + BAout + Cout + Rout) > 1)
      bus_viol++;
    if (Read && Write) rw_viol++;
    if (HIin && LOin) hilo_viol++;
    if (exp_q.size() != 0) begin
      ctl_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL step_compare t=%0t ir=%h got=%h want=%h", $time, IR, obs, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Called at posedge+1 while in T0; returns at posedge+1 of the following state.
  task automatic run_instr(input logic [31:0] ir, input logic stop, input int lit_idx,
                           input logic [4:0] lit_alu, input int only_steps);
    logic [4:0] op;
    int n;
    op = ir[31:27];
    n = (only_steps > 0) ? only_steps : n_steps(op);
    IR = ir;
    Stop = stop;
    for (int i = 0; i < n; i++) exp_q.push_back(step_vec(op, i));
    for (int i = 0; i < n; i++) begin
      if (i == lit_idx) check("lit_alu_op", {27'd0, alu_op}, {27'd0, lit_alu});
      tick();
    end
    Stop = 1'b0;
  endtask

  task automatic hold_halt(input int k);
    for (int i = 0; i < k; i++) exp_q.push_back(ctl_t'(0));
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic do_reset();
    clear = 1'b1;
    #1;
    check("clear_async_zero", {2'b0, obs}, 32'h0);
    tick();
    clear = 1'b0;
    exp_q.push_back(ctl_t'(0));
    tick();
    check("t0_after_reset", {27'd0, PCout, MARin, IncPC, Zin, Run}, 32'h1f);
  endtask

  task automatic run_op(input logic [4:0] op, input logic stop);
    run_instr({op, 27'h0123456}, stop, -1, 5'd0, 0);
    if (ends_in_halt(op, stop)) begin
      hold_halt(3);
      do_reset();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_zero", {2'b0, obs}, 32'h0);
    tick();
    clear = 1'b0;
    exp_q.push_back(ctl_t'(0));
    tick();
    check("t0_first", {27'd0, PCout, MARin, IncPC, Zin, Run}, 32'h1f);

    // Clear pulsed inside T4 of an add (partial run, then async clear mid-cycle).
    run_instr({5'b00011, 27'h0}, 1'b0, -1, 5'd0, 4);
    check("in_t4_before_clear", {27'd0, Grc, Rout, Zin, Run, 1'b0}, 32'h1e);
    do_reset();

    // and R1,R2,R3, then T0 again after six steps.
    run_instr(32'h28918000, 1'b0, 4, 5'b00101, 0);
    check("t0_after_and", {27'd0, PCout, MARin, IncPC, Zin, Run}, 32'h1f);

    foreach (exp_q[i]) ;
    run_op(5'd3, 0);  run_op(5'd4, 0);  run_op(5'd6, 0);  run_op(5'd7, 0);
    run_op(5'd8, 0);  run_op(5'd9, 0);  run_op(5'd10, 0);
    run_op(5'd11, 0); run_op(5'd12, 0); run_op(5'd13, 0);
    run_op(5'd16, 0); run_op(5'd17, 0);
    run_op(5'd14, 0); run_op(5'd15, 0);
    run_op(5'd1, 0);  run_op(5'd0, 0);  run_op(5'd2, 0);
    run_op(5'd24, 0);

    // Stop held through a whole add: only the final step honours it.
    run_instr({5'd3, 27'h0}, 1'b1, -1, 5'd0, 0);
    check("run_low_after_stop", {31'd0, Run}, 32'h0);
    hold_halt(5);
    do_reset();

    // halt instruction: 20 quiet cycles.
    run_instr({5'd25, 27'h0}, 1'b0, -1, 5'd0, 0);
    check("run_low_after_halt", {31'd0, Run}, 32'h0);
    hold_halt(20);
    do_reset();

    // Unlisted opcodes.
`ifdef CONTROL_ILLEGAL_TRAP_EN
    run_instr({5'd31, 27'h0}, 1'b0, -1, 5'd0, 0);
    hold_halt(3);
    check("illegal_set", {31'd0, illegal}, 32'h1);
    check("illegal_run_low", {31'd0, Run}, 32'h0);
    do_reset();
    check("illegal_cleared", {31'd0, illegal}, 32'h0);
    run_op(5'd18, 0);
`else
    run_instr({5'd31, 27'h0}, 1'b0, -1, 5'd0, 0);
    check("t0_after_unlisted", {27'd0, PCout, MARin, IncPC, Zin, Run}, 32'h1f);
    run_op(5'd18, 0);
    run_op(5'd26, 0);
`endif

    tick();
    check("queue_drained", exp_q.size(), 32'h0);
    check("bus_onehot0", bus_viol, 32'h0);
    check("read_write_excl", rw_viol, 32'h0);
    check("hi_lo_excl", hilo_viol, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
